// File: rtl/berger_mem_scrub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : berger_mem_scrub_ctrl
// Brief    : Host/scrub sequencer with read retry and error statistics in
//            front of a Berger-coded memory. Define BERGER_SCRUB_EN to build
//            the background scrubber; without it scrub_en is ignored.
// Revision : 1.0  initial release
// ============================================================================
module berger_mem_scrub_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int MAX_RETRY      = 2,
  parameter int SCRUB_INTERVAL = 16,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_req,
  input  logic                     host_we,
  input  logic [ADDR_WIDTH-1:0]    host_addr,
  input  logic [DATA_WIDTH-1:0]    host_wdata,
  output logic                     host_ready,
  output logic                     host_rvalid,
  output logic [DATA_WIDTH-1:0]    host_rdata,
  output logic                     host_rerr,
  input  logic                     scrub_en,
  input  logic                     err_clr,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     mem_wr_en,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    last_err_addr,
  output logic                     err_sticky
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_SCRUB = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [RETRY_W-1:0]       retry_q, retry_d;
  logic                     rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     rerr_q, rerr_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]    eaddr_q, eaddr_d;
  logic                     sticky_q, sticky_d;
  logic                     rec_fail;

`ifdef BERGER_SCRUB_EN
  localparam int IVL_W = $clog2(SCRUB_INTERVAL + 1);
  logic [ADDR_WIDTH-1:0]    ptr_q, ptr_d;
  logic [IVL_W-1:0]         ivl_q, ivl_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      ivl_q <= IVL_W'(SCRUB_INTERVAL);
    end else begin
      ptr_q <= ptr_d;
      ivl_q <= ivl_d;
    end
  end
`else
  // Scrubber compiled out: its inputs are deliberately sunk here.
  logic scrub_unused;
  assign scrub_unused = scrub_en | (SCRUB_INTERVAL < 1);
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    retry_d  = retry_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    rec_fail = 1'b0;
`ifdef BERGER_SCRUB_EN
    ptr_d    = ptr_q;
    ivl_d    = ivl_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef BERGER_SCRUB_EN
        if (scrub_en && (ivl_q != '0)) ivl_d = ivl_q - 1'b1;
`endif
        // Host always wins arbitration; a due scrub simply waits at zero.
        if (host_req) begin
          addr_d = host_addr;
          if (host_we) begin
            wdata_d = host_wdata;
            state_d = ST_WRITE;
          end else begin
            retry_d = '0;
            state_d = ST_READ;
          end
        end
`ifdef BERGER_SCRUB_EN
        else if (scrub_en && (ivl_q == '0)) begin
          addr_d  = ptr_q;
          state_d = ST_SCRUB;
        end
`endif
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ: begin
        if (!mem_err) begin
          rvalid_d = 1'b1;
          rdata_d  = mem_rdata;
          rerr_d   = 1'b0;
          state_d  = ST_IDLE;
        end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
        end else begin
          rvalid_d = 1'b1;
          rdata_d  = mem_rdata;
          rerr_d   = 1'b1;
          rec_fail = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_SCRUB: begin
`ifdef BERGER_SCRUB_EN
        rec_fail = mem_err;
        ptr_d    = ptr_q + 1'b1;
        ivl_d    = IVL_W'(SCRUB_INTERVAL);
`endif
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_d    = cnt_q;
    eaddr_d  = eaddr_q;
    sticky_d = sticky_q;
    if (err_clr) begin
      cnt_d    = '0;
      eaddr_d  = '0;
      sticky_d = 1'b0;
    end
    // A failure in the same cycle as a clear survives the clear.
    if (rec_fail) begin
      if (err_clr)           cnt_d = ERR_CNT_WIDTH'(1);
      else if (cnt_q != '1)  cnt_d = cnt_q + 1'b1;
      eaddr_d  = addr_q;
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      retry_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      cnt_q    <= '0;
      eaddr_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      retry_q  <= retry_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      cnt_q    <= cnt_d;
      eaddr_q  <= eaddr_d;
      sticky_q <= sticky_d;
    end
  end

  assign host_ready    = (state_q == ST_IDLE);
  assign host_rvalid   = rvalid_q;
  assign host_rdata    = rdata_q;
  assign host_rerr     = rerr_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wr_en     = (state_q == ST_WRITE);
  assign err_count     = cnt_q;
  assign last_err_addr = eaddr_q;
  assign err_sticky    = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_berger_mem_scrub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_berger_mem_scrub_ctrl
// Brief    : Randomized self-checking bench for berger_mem_scrub_ctrl with a
//            behavioural memory and transaction-level expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_berger_mem_scrub_ctrl;

  localparam int MR = 2;
  localparam int SI = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [3:0]  host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        host_ready, host_rvalid, host_rerr;
  logic [7:0]  host_rdata;
  logic        scrub_en = 1'b0, err_clr = 1'b0;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_wr_en, mem_err;
  logic [15:0] err_count;
  logic [3:0]  last_err_addr;
  logic        err_sticky;

  logic [7:0]  bench_mem [16];
  logic        fault_map [16];
  logic        force_err = 1'b0;

  logic [7:0]  model_mem [16];
  int          exp_cnt = 0;
  logic [3:0]  exp_last = '0;
  logic        exp_sticky = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  berger_mem_scrub_ctrl dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_rerr(host_rerr),
    .scrub_en(scrub_en), .err_clr(err_clr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .err_count(err_count), .last_err_addr(last_err_addr), .err_sticky(err_sticky)
  );

  // Behavioural memory: combinational read, error flag from the fault map or a per-cycle override.
  assign mem_rdata = bench_mem[mem_addr];
  assign mem_err   = fault_map[mem_addr] | force_err;
  always @(posedge clk) if (mem_wr_en) bench_mem[mem_addr] <= mem_wdata;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_write(input logic [3:0] a, input logic [7:0] d, output int wr_at,
                             output int pulses, output logic [3:0] wa, output logic [7:0] wd);
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    wr_at = 0; pulses = 0; wa = '0; wd = '0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      host_req = 1'b0;
      if (mem_wr_en) begin
        pulses++;
        if (wr_at == 0) begin wr_at = n; wa = mem_addr; wd = mem_wdata; end
      end
    end
  endtask

  // nfail = number of leading read attempts that see mem_err forced high.
  task automatic drive_read(input logic [3:0] a, input int nfail, input bit clr_on_last,
                            output int lat, output logic [7:0] rd, output logic re,
                            output int pulses, output bit addr_ok);
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = a; host_wdata = 8'($urandom);
    lat = 0; pulses = 0; rd = '0; re = 1'b0; addr_ok = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      host_req = 1'b0;
      err_clr  = 1'b0;
      if (host_rvalid) begin
        pulses++;
        force_err = 1'b0;
        if (lat == 0) begin lat = n; rd = host_rdata; re = host_rerr; end
      end else if (lat == 0) begin
        if (mem_addr !== a || host_ready !== 1'b0) addr_ok = 1'b0;
        force_err = ((n - 1) < nfail);
        if (clr_on_last && (n - 1) == MR) err_clr = 1'b1;
      end
      if (lat != 0 && n >= lat + 2) break;
    end
    force_err = 1'b0;
    err_clr   = 1'b0;
  endtask

  function automatic void note_fail(input logic [3:0] a, input bit with_clr);
    exp_cnt    = with_clr ? 1 : ((exp_cnt == 65535) ? exp_cnt : exp_cnt + 1);
    exp_last   = a;
    exp_sticky = 1'b1;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h exp 1", host_ready); end
    checks++; if (host_rvalid !== 1'b0 || host_rerr !== 1'b0 || host_rdata !== 8'h00) begin errors++; $display("FAIL reset_host_out got rv=%0h re=%0h rd=%0h exp 0 0 0", host_rvalid, host_rerr, host_rdata); end
    checks++; if (mem_wr_en !== 1'b0 || mem_addr !== 4'h0 || mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_out got we=%0h a=%0h d=%0h exp 0 0 0", mem_wr_en, mem_addr, mem_wdata); end
    checks++; if (err_count !== 16'h0 || last_err_addr !== 4'h0 || err_sticky !== 1'b0) begin errors++; $display("FAIL reset_stats got %0h %0h %0h exp 0 0 0", err_count, last_err_addr, err_sticky); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int wr_at, pulses, lat; logic [3:0] wa; logic [7:0] wd, rd; logic re; bit ok;
    drive_write(4'd3, 8'hA5, wr_at, pulses, wa, wd);
    model_mem[3] = 8'hA5;
    checks++; if (wr_at !== 1 || pulses !== 1) begin errors++; $display("FAIL write_pulse got at=%0d n=%0d exp at=1 n=1", wr_at, pulses); end
    checks++; if (wa !== 4'd3 || wd !== 8'hA5) begin errors++; $display("FAIL write_bus got a=%0h d=%0h exp 3 a5", wa, wd); end
    drive_read(4'd3, 0, 1'b0, lat, rd, re, pulses, ok);
    checks++; if (lat !== 2 || pulses !== 1) begin errors++; $display("FAIL read_latency got lat=%0d n=%0d exp 2 1", lat, pulses); end
    checks++; if (rd !== 8'hA5 || re !== 1'b0) begin errors++; $display("FAIL read_data got %0h err=%0h exp a5 0", rd, re); end
    checks++; if (!ok) begin errors++; $display("FAIL read_addr got bad mem_addr/ready exp addr 3 busy"); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL read_cnt got %0h exp 0", err_count); end
  endtask

  task automatic test_fill();
    int wr_at, pulses; logic [3:0] wa; logic [7:0] wd, d;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      drive_write(4'(i), d, wr_at, pulses, wa, wd);
      model_mem[i] = d;
      checks++; if (pulses !== 1 || wa !== 4'(i) || wd !== d) begin errors++; $display("FAIL fill_%0d got n=%0d a=%0h d=%0h exp 1 %0h %0h", i, pulses, wa, wd, i, d); end
    end
  endtask

  task automatic test_retry();
    int lat, pulses; logic [7:0] rd; logic re; bit ok;
    drive_read(4'd1, 1, 1'b0, lat, rd, re, pulses, ok);
    checks++; if (lat !== 3 || pulses !== 1) begin errors++; $display("FAIL retry_latency got lat=%0d n=%0d exp 3 1", lat, pulses); end
    checks++; if (rd !== model_mem[1] || re !== 1'b0) begin errors++; $display("FAIL retry_data got %0h err=%0h exp %0h 0", rd, re, model_mem[1]); end
    checks++; if (err_count !== 16'(exp_cnt) || err_sticky !== exp_sticky) begin errors++; $display("FAIL retry_stats got %0h %0h exp %0h %0h", err_count, err_sticky, exp_cnt, exp_sticky); end
  endtask

  task automatic test_fail();
    int lat, pulses; logic [7:0] rd; logic re; bit ok;
    fault_map[2] = 1'b1;
    drive_read(4'd2, 0, 1'b0, lat, rd, re, pulses, ok);
    fault_map[2] = 1'b0;
    note_fail(4'd2, 1'b0);
    checks++; if (lat !== MR + 2 || pulses !== 1) begin errors++; $display("FAIL fail_latency got lat=%0d n=%0d exp %0d 1", lat, pulses, MR + 2); end
    checks++; if (re !== 1'b1 || rd !== model_mem[2]) begin errors++; $display("FAIL fail_resp got err=%0h rd=%0h exp 1 %0h", re, rd, model_mem[2]); end
    checks++; if (err_count !== 16'(exp_cnt) || last_err_addr !== exp_last || err_sticky !== exp_sticky) begin errors++; $display("FAIL fail_stats got %0h %0h %0h exp %0h %0h %0h", err_count, last_err_addr, err_sticky, exp_cnt, exp_last, exp_sticky); end
  endtask

  task automatic test_err_clr();
    int lat, pulses; logic [7:0] rd; logic re; bit ok;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    exp_cnt = 0; exp_last = '0; exp_sticky = 1'b0;
    checks++; if (err_count !== 16'h0 || last_err_addr !== 4'h0 || err_sticky !== 1'b0) begin errors++; $display("FAIL clr_stats got %0h %0h %0h exp 0 0 0", err_count, last_err_addr, err_sticky); end
    fault_map[7] = 1'b1;
    drive_read(4'd7, 0, 1'b0, lat, rd, re, pulses, ok);
    fault_map[7] = 1'b0;
    note_fail(4'd7, 1'b0);
    fault_map[9] = 1'b1;
    drive_read(4'd9, 0, 1'b1, lat, rd, re, pulses, ok);
    fault_map[9] = 1'b0;
    note_fail(4'd9, 1'b1);
    checks++; if (err_count !== 16'(exp_cnt) || last_err_addr !== exp_last || err_sticky !== exp_sticky) begin errors++; $display("FAIL clr_vs_fail got %0h %0h %0h exp %0h %0h %0h", err_count, last_err_addr, err_sticky, exp_cnt, exp_last, exp_sticky); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    d = 8'($urandom);
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'd12; host_wdata = d;
    @(negedge clk);
    checks++; if (host_ready !== 1'b0 || mem_wr_en !== 1'b1) begin errors++; $display("FAIL b2b_write got rdy=%0h we=%0h exp 0 1", host_ready, mem_wr_en); end
    host_we = 1'b0;
    @(negedge clk);
    checks++; if (host_ready !== 1'b1 || mem_wr_en !== 1'b0) begin errors++; $display("FAIL b2b_idle got rdy=%0h we=%0h exp 1 0", host_ready, mem_wr_en); end
    @(negedge clk);
    host_req = 1'b0;
    @(negedge clk);
    model_mem[12] = d;
    checks++; if (host_rvalid !== 1'b1 || host_rdata !== d || host_rerr !== 1'b0) begin errors++; $display("FAIL b2b_read got rv=%0h rd=%0h re=%0h exp 1 %0h 0", host_rvalid, host_rdata, host_rerr, d); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int wr_at, pulses, lat, nfail, exp_lat; logic [3:0] a, wa; logic [7:0] d, wd, rd; logic re; bit ok;
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        drive_write(a, d, wr_at, pulses, wa, wd);
        model_mem[a] = d;
        checks++; if (wr_at !== 1 || pulses !== 1 || wa !== a || wd !== d) begin errors++; $display("FAIL rnd_write_%0d got at=%0d n=%0d a=%0h d=%0h exp 1 1 %0h %0h", i, wr_at, pulses, wa, wd, a, d); end
      end else begin
        nfail = int'($urandom_range(0, 3));
        drive_read(a, nfail, 1'b0, lat, rd, re, pulses, ok);
        exp_lat = (nfail > MR) ? MR + 2 : nfail + 2;
        if (nfail > MR) note_fail(a, 1'b0);
        checks++; if (lat !== exp_lat || pulses !== 1 || !ok) begin errors++; $display("FAIL rnd_read_%0d got lat=%0d n=%0d ok=%0d exp %0d 1 1", i, lat, pulses, ok, exp_lat); end
        checks++; if (rd !== model_mem[a] || re !== (nfail > MR)) begin errors++; $display("FAIL rnd_rdata_%0d got %0h err=%0h exp %0h %0h", i, rd, re, model_mem[a], nfail > MR); end
      end
      checks++; if (err_count !== 16'(exp_cnt) || last_err_addr !== exp_last || err_sticky !== exp_sticky) begin errors++; $display("FAIL rnd_stats_%0d got %0h %0h %0h exp %0h %0h %0h", i, err_count, last_err_addr, err_sticky, exp_cnt, exp_last, exp_sticky); end
    end
  endtask

  task automatic test_reset_mid_read();
    int rv = 0;
    int busy = 0;
    fault_map[6] = 1'b1;
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'd6;
    @(negedge clk);
    host_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (host_ready !== 1'b1 || host_rvalid !== 1'b0 || mem_addr !== 4'h0 || mem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_mid_out got rdy=%0h rv=%0h a=%0h we=%0h exp 1 0 0 0", host_ready, host_rvalid, mem_addr, mem_wr_en); end
    checks++; if (err_count !== 16'h0 || err_sticky !== 1'b0 || last_err_addr !== 4'h0 || host_rdata !== 8'h00) begin errors++; $display("FAIL rst_mid_stats got %0h %0h %0h rd=%0h exp 0 0 0 0", err_count, err_sticky, last_err_addr, host_rdata); end
    fault_map[6] = 1'b0;
    exp_cnt = 0; exp_last = '0; exp_sticky = 1'b0;
    repeat (2) begin @(negedge clk); if (host_rvalid) rv++; end
    rst = 1'b0;
    repeat (5) begin @(negedge clk); if (host_rvalid) rv++; if (!host_ready) busy++; end
    checks++; if (rv !== 0 || busy !== 0) begin errors++; $display("FAIL rst_mid_quiet got rvalid=%0d busy=%0d exp 0 0", rv, busy); end
  endtask

`ifdef BERGER_SCRUB_EN
  logic [3:0] exp_ptr = '0;

  task automatic test_scrub();
    int seen = 0;
    int idle_run = 0;
    bit pending = 1'b0;
    fault_map[5] = 1'b1;
    @(negedge clk);
    scrub_en = 1'b1;
    for (int n = 0; n < 2000 && seen < 33; n++) begin
      @(negedge clk);
      if (!host_ready) begin
        checks++; if (mem_addr !== exp_ptr) begin errors++; $display("FAIL scrub_addr_%0d got %0h exp %0h", seen, mem_addr, exp_ptr); end
        if (seen > 0) begin
          checks++; if (idle_run !== SI + 1) begin errors++; $display("FAIL scrub_gap_%0d got %0d exp %0d", seen, idle_run, SI + 1); end
        end
        pending = (exp_ptr == 4'd5);
        exp_ptr = exp_ptr + 4'd1;
        seen++;
        idle_run = 0;
      end else begin
        if (pending) begin
          note_fail(4'd5, 1'b0);
          checks++; if (err_count !== 16'(exp_cnt) || last_err_addr !== 4'd5 || err_sticky !== 1'b1) begin errors++; $display("FAIL scrub_stats got %0h %0h %0h exp %0h 5 1", err_count, last_err_addr, err_sticky, exp_cnt); end
          pending = 1'b0;
        end
        idle_run++;
      end
    end
    checks++; if (seen !== 33) begin errors++; $display("FAIL scrub_count got %0d exp 33", seen); end
    checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL scrub_passes got %0h exp 2", err_count); end
  endtask

  task automatic test_host_priority();
    bit found = 1'b0;
    int busy = 0;
    for (int k = 1; k <= SI + 1; k++) @(negedge clk);
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL prio_idle got %0h exp 1", host_ready); end
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'd3;
    @(negedge clk);
    host_req = 1'b0;
    checks++; if (host_ready !== 1'b0 || mem_addr !== 4'd3) begin errors++; $display("FAIL prio_host got rdy=%0h a=%0h exp 0 3", host_ready, mem_addr); end
    @(negedge clk);
    checks++; if (host_rvalid !== 1'b1 || host_rdata !== model_mem[3]) begin errors++; $display("FAIL prio_resp got rv=%0h rd=%0h exp 1 %0h", host_rvalid, host_rdata, model_mem[3]); end
    @(negedge clk);
    checks++; if (host_ready !== 1'b0 || mem_addr !== exp_ptr) begin errors++; $display("FAIL prio_scrub got rdy=%0h a=%0h exp 0 %0h", host_ready, mem_addr, exp_ptr); end
    exp_ptr = exp_ptr + 4'd1;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (!host_ready) begin
        if (exp_ptr == 4'd5) begin err_clr = 1'b1; found = 1'b1; end
        exp_ptr = exp_ptr + 4'd1;
      end
    end
    @(negedge clk);
    err_clr = 1'b0;
    note_fail(4'd5, 1'b1);
    checks++; if (!found || err_count !== 16'd1 || err_sticky !== 1'b1 || last_err_addr !== 4'd5) begin errors++; $display("FAIL scrub_clr got found=%0d %0h %0h %0h exp 1 1 1 5", found, err_count, err_sticky, last_err_addr); end
    scrub_en = 1'b0;
    repeat (60) begin @(negedge clk); if (!host_ready) busy++; end
    checks++; if (busy !== 0) begin errors++; $display("FAIL scrub_disable got busy=%0d exp 0", busy); end
    fault_map[5] = 1'b0;
  endtask
`else
  task automatic test_scrub_ignored();
    int busy = 0;
    int wr = 0;
    fault_map[5] = 1'b1;
    @(negedge clk);
    scrub_en = 1'b1;
    repeat (60) begin @(negedge clk); if (!host_ready) busy++; if (mem_wr_en) wr++; end
    scrub_en = 1'b0;
    fault_map[5] = 1'b0;
    checks++; if (busy !== 0 || wr !== 0) begin errors++; $display("FAIL scrub_ignored got busy=%0d wr=%0d exp 0 0", busy, wr); end
    checks++; if (err_count !== 16'(exp_cnt) || err_sticky !== exp_sticky) begin errors++; $display("FAIL scrub_ignored_stats got %0h %0h exp %0h %0h", err_count, err_sticky, exp_cnt, exp_sticky); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) fault_map[i] = 1'b0;
    test_reset();
    test_write_read();
    test_fill();
    test_retry();
    test_fail();
    test_err_clr();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
`ifdef BERGER_SCRUB_EN
    test_scrub();
    test_host_priority();
`else
    test_scrub_ignored();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
